// File: rtl/pipe_stage_buf.sv
// Elastic pipeline buffer: a DEPTH-entry FIFO between two valid/ready stages.
// Define PIPE_STAGE_BUBBLE_CNT_EN to add a saturating 16-bit bubble-cycle counter.
module pipe_stage_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  ,
  output logic [15:0]                bubbles
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push;
  logic             pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  // Counts idle output cycles; survives flush so stalls stay visible.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bubbles <= '0;
    end else if (!out_valid && (bubbles != 16'hFFFF)) begin
      bubbles <= bubbles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH=2 and DEPTH=3 instances share stimulus and are
// compared every cycle against queue-based models, plus literal directed checks.
module tb_pipe_stage_buf;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         in_ready2, out_valid2, in_ready3, out_valid3;
  logic [W-1:0] out_data2, out_data3;
  logic [1:0]   count2, count3;
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  logic [15:0]  bubbles2, bubbles3;
`endif

  logic [W-1:0] q2 [$];
  logic [W-1:0] q3 [$];
  int           bub2 = 0;
  int           bub3 = 0;
  bit           model_on = 1'b0;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(W), .DEPTH(2)) dut2 (
    .CLK(clk), .RST(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
    .count(count2)
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    , .bubbles(bubbles2)
`endif
  );

  pipe_stage_buf #(.WIDTH(W), .DEPTH(3)) dut3 (
    .CLK(clk), .RST(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready),
    .count(count3)
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    , .bubbles(bubbles3)
`endif
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Continuous comparison of both instances against their models.
  task automatic checkOutput();
    check("count2", W'(count2), W'(q2.size()));
    check("in_ready2", W'(in_ready2), W'(q2.size() < 2));
    check("out_valid2", W'(out_valid2), W'(q2.size() != 0));
    if (q2.size() != 0) check("out_data2", out_data2, q2[0]);
    check("count3", W'(count3), W'(q3.size()));
    check("in_ready3", W'(in_ready3), W'(q3.size() < 3));
    check("out_valid3", W'(out_valid3), W'(q3.size() != 0));
    if (q3.size() != 0) check("out_data3", out_data3, q3[0]);
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    check("bubbles2", W'(bubbles2), W'(bub2));
    check("bubbles3", W'(bubbles3), W'(bub3));
`endif
  endtask

  always @(negedge clk) begin
    if (model_on) checkOutput();
  end

  // Drive one cycle of inputs, advance the models at the edge, return at edge+1.
  task automatic applyStimulus(input bit r, input bit f, input bit iv,
                               input logic [W-1:0] d, input bit orr);
    int  sz2, sz3;
    bit  push2, pop2, push3, pop3;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = orr;
    sz2 = q2.size();
    sz3 = q3.size();
    push2 = iv && (sz2 < 2) && !f;
    pop2  = (sz2 != 0) && orr && !f;
    push3 = iv && (sz3 < 3) && !f;
    pop3  = (sz3 != 0) && orr && !f;
    @(posedge clk);
    if (r) begin
      q2.delete(); q3.delete();
      bub2 = 0; bub3 = 0;
      model_on = 1'b1;
    end else begin
      if (sz2 == 0 && bub2 < 65535) bub2++;
      if (sz3 == 0 && bub3 < 65535) bub3++;
      if (f) begin
        q2.delete(); q3.delete();
      end else begin
        if (pop2) void'(q2.pop_front());
        if (push2) q2.push_back(d);
        if (pop3) void'(q3.pop_front());
        if (push3) q3.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    // Reset then idle
    applyStimulus(1, 0, 0, '0, 0);
    check("rst_count2", W'(count2), W'(0));
    check("rst_in_ready2", W'(in_ready2), W'(1));
    check("rst_out_valid2", W'(out_valid2), W'(0));
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, '0, 0);
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
      check("idle_bubbles2", W'(bubbles2), W'(i));
`endif
    end

    // Fill DEPTH=2, overflow push ignored, then drain in order
    applyStimulus(0, 0, 1, 64'hA, 0);
    applyStimulus(0, 0, 1, 64'hB, 0);
    check("fill_count2", W'(count2), W'(2));
    check("fill_in_ready2", W'(in_ready2), W'(0));
    check("fill_head2", out_data2, 64'hA);
    applyStimulus(0, 0, 1, 64'hC, 0);
    check("ovf_count2", W'(count2), W'(2));
    check("ovf_head2", out_data2, 64'hA);
    check("d3_count_after_c", W'(count3), W'(3));
    applyStimulus(0, 0, 0, '0, 1);
    check("pop1_head2", out_data2, 64'hB);
    applyStimulus(0, 0, 0, '0, 1);
    check("pop2_count2", W'(count2), W'(0));

    // Streaming 1..8 from empty
    applyStimulus(0, 1, 0, '0, 0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 1, W'(k), 1);
      check("stream_data2", out_data2, W'(k));
      check("stream_count2", W'(count2), W'(1));
    end

    // Flush collides with push 0x5 and pop at count=1
    applyStimulus(0, 1, 1, 64'h5, 1);
    check("flush_count2", W'(count2), W'(0));
    check("flush_valid2", W'(out_valid2), W'(0));
    applyStimulus(0, 0, 0, '0, 0);
    check("flush_stays_empty2", W'(out_valid2), W'(0));

    // DEPTH=3 wrap: interleaved pushes and pops of 1..7
    applyStimulus(0, 0, 1, 64'd1, 0);
    applyStimulus(0, 0, 1, 64'd2, 0);
    applyStimulus(0, 0, 1, 64'd3, 0);
    check("wrap_full3", W'(count3), W'(3));
    check("wrap_in_ready3", W'(in_ready3), W'(0));
    applyStimulus(0, 0, 1, 64'd4, 1);
    check("wrap_head3_after_pop", out_data3, 64'd2);
    applyStimulus(0, 0, 1, 64'd4, 0);
    applyStimulus(0, 0, 1, 64'd5, 1);
    applyStimulus(0, 0, 1, 64'd5, 0);
    applyStimulus(0, 0, 1, 64'd6, 1);
    applyStimulus(0, 0, 1, 64'd6, 0);
    check("wrap_head3", out_data3, 64'd4);
    applyStimulus(0, 0, 1, 64'd7, 1);
    applyStimulus(0, 0, 1, 64'd7, 1);
    check("wrap_head3_late", out_data3, 64'd6);

    // Reset mid-stream with a concurrent push
    applyStimulus(0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, 64'h11, 0);
    applyStimulus(0, 0, 1, 64'h22, 0);
    check("pre_rst_count2", W'(count2), W'(2));
    applyStimulus(1, 0, 1, 64'h33, 0);
    check("mid_rst_count2", W'(count2), W'(0));
    check("mid_rst_count3", W'(count3), W'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                    ($urandom_range(3) != 0), {$urandom, $urandom},
                    ($urandom_range(2) != 0));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, which sets the payload bit width (minimum 1).
REQ-002 The block SHALL have parameter DEPTH, default 2, which sets the number of buffered entries (minimum 1).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: discard all buffered entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream stage presents a payload.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the buffer accepts a payload this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: the head entry payload.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the head this cycle.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH+1) bits: the number of occupied entries.
REQ-013 With PIPE_STAGE_BUBBLE_CNT_EN defined, the block SHALL have port bubbles, output, 16 bits: the bubble-cycle count.

Function
REQ-014 The block SHALL implement a FIFO of DEPTH entries, each WIDTH bits.
REQ-015 A push SHALL occur only when in_valid=1, in_ready=1 and flush=0.
REQ-016 A pop SHALL occur only when out_valid=1, out_ready=1 and flush=0.
REQ-017 in_ready SHALL equal (count < DEPTH), a registered-state function with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (count != 0), and out_data SHALL equal the oldest entry; out_data is don't-care when out_valid=0.
REQ-019 Latency SHALL be 1 cycle: a payload pushed at edge N appears on out_data after edge N when the FIFO was empty.
REQ-020 On a simultaneous push and pop, count SHALL be unchanged and order preserved; at count=DEPTH no push occurs because in_ready=0.
REQ-021 The read and write pointers SHALL wrap from DEPTH-1 to 0; for DEPTH not a power of two, explicit modulo-DEPTH wrap is required.
REQ-022 flush=1 SHALL set count to 0 and both pointers to 0 at the next edge, overriding any push or pop in the same cycle.
REQ-023 Payload storage SHALL not need clearing on flush or reset.
REQ-024 out_ready with out_valid=0, and in_valid with in_ready=0, SHALL have no effect.

Reset
REQ-025 At the RST edge, count, both pointers and (when compiled in) bubbles SHALL be set to 0, giving in_ready=1 and out_valid=0.
REQ-026 RST SHALL take priority over flush, push and pop.
REQ-027 RST asserted mid-operation SHALL discard all entries, with no partial state retained.

Configuration
REQ-028 With macro PIPE_STAGE_BUBBLE_CNT_EN defined, bubbles SHALL increment by 1 each cycle with out_valid=0 and RST=0, saturating at 16'hFFFF; flush SHALL not clear it.
REQ-029 With PIPE_STAGE_BUBBLE_CNT_EN undefined, the bubbles port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Reset then idle: RST=1 for 1 cycle -> count=0, in_ready=1, out_valid=0; bubbles increments 1,2,3 on following idle cycles.
REQ-031 Fill with DEPTH=2 and out_ready=0: push 0xA, 0xB -> count=2, in_ready=0, out_data=0xA; a third push of 0xC is ignored; with out_ready=1, pops yield 0xA, then 0xB.
REQ-032 Streaming: in_valid=1 and out_ready=1 continuously with values 1..8 -> out_data delivers 1..8 in order one cycle later, count stays 1, no bubbles after the first beat.
REQ-033 Flush collision: count=1, push 0x5 and pop with flush=1 in the same cycle -> count=0 next cycle, and 0x5 never appears on the output.
REQ-034 Wrap with DEPTH=3: push and pop 7 items interleaved -> order preserved across pointer wrap, count never exceeds 3.
REQ-035 Reset mid-stream: count=2, RST=1 together with in_valid=1 -> count=0 next cycle, and the pushed item is discarded.
